ap_handshake_tracker: RTL and testbench
=======================================

# ap_handshake_tracker

Synthesizable per-module handshake tracker for the co-simulation dataflow monitor path. It watches one kernel's ap_ctrl_hs signals (ap_start, ap_ready, ap_done, ap_continue) and timestamps each accepted start and each completion. It emits one record per completed transaction (start time, done time, latency, start-to-start interval) on a valid/ready stream. The monitor consumes these records through its CSV dump agents in place of sampling raw handshake wires.

## Interface
- TS_W, 32: timestamp and record-field width.
- OUT_DEPTH, 8: output record FIFO depth; power of 2, ≥2.
- MAX_OUT, 4: maximum transactions in flight (accepted start, done not yet seen); power of 2, ≥1.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  arms tracking; sampled in IDLE only.
- finish  in  1  end of simulation; starts the drain.
- ap_start, ap_ready, ap_done, ap_continue  in  1 each  observed handshake of the tracked kernel.
- rec_valid  out  1  a record is present at the FIFO head.
- rec_ready  in  1  consumer accepts the record.
- rec_start_ts, rec_done_ts, rec_latency, rec_interval  out  TS_W each  fields of the head record.
- err_overflow  out  1  sticky; a record was dropped because the output FIFO was full.
- err_orphan  out  1  sticky; a done arrived with no transaction in flight.
- err_excess  out  1  sticky; a start arrived while MAX_OUT transactions were in flight.
- drop_count  out  16  saturating count of dropped records.
- drained  out  1  high in DONE.

## Operation
- FSM states:
  - IDLE: go to RUN when enable is high.
  - RUN: go to DRAIN when finish is high.
  - DRAIN: go to DONE when the output FIFO is empty.
  - DONE: terminal until reset.
- Timestamp `cyc`:
  - TS_W-bit counter, cleared by reset.
  - Increments once per cycle in RUN only; holds in all other states.
  - Wraps modulo 2^TS_W.
- Events are detected in RUN only:
  - Start event: ap_start & ap_ready.
  - Done event: ap_done & ap_continue.
- On a start event, push {start_ts = cyc, interval} into the in-flight queue.
  - interval = cyc − last start_ts, modulo 2^TS_W.
  - interval = 0 for the first start after reset.
  - last start_ts is updated on every start event, including one rejected with err_excess.
- Done event with the queue non-empty:
  - Pop the oldest entry.
  - done_ts = cyc; latency = done_ts − start_ts, modulo 2^TS_W.
  - Push the record to the output FIFO.
- Done event with the queue empty and a start event in the same cycle: bypass the queue and emit a record with latency 0.
- Done event with the queue empty and no start in the same cycle: set err_orphan; no record.
- Start event with the queue full and no pop in the same cycle: set err_excess; the start is not tracked. A same-cycle pop frees the slot and the start is accepted.
- Output FIFO full with no pop this cycle: drop the record, set err_overflow, increment drop_count (saturates at 0xFFFF). A same-cycle pop (rec_valid & rec_ready) frees space and the push succeeds.
- DRAIN and DONE:
  - No new events are recorded.
  - The output stream continues until the FIFO is empty.
  - In-flight entries are discarded silently.
- Reset in any state:
  - Empties both FIFOs, clears all sticky flags and drop_count, returns to IDLE.
  - Reset outputs: rec_valid=0, rec_* fields=0, err_*=0, drop_count=0, drained=0.

## Timing
- Event in cycle N updates the queue or FIFO at the edge ending N.
- The output FIFO is first-word-fall-through: rec_valid rises in cycle N+1 when the FIFO was empty.
- Record fields are stable while rec_valid & !rec_ready; a pop advances the head on the next cycle.
- The first timestamp after entering RUN is 0.
- drained rises in the cycle after the FIFO empties while in DRAIN.
- Throughput: one start and one done per cycle sustained; one record out per cycle.

## Structure
- Package hs_track_pkg:
  - rec_t struct {start_ts, done_ts, latency, interval}.
  - inflight_t struct {start_ts, interval}.
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Default width constants.
- Sub-module hs_track_fifo: parameterized synchronous FWFT FIFO (WIDTH, DEPTH) with full/empty flags and a count. Instanced twice: in-flight queue (depth MAX_OUT) and output FIFO (depth OUT_DEPTH).

## Test plan
- Single transaction: enable, start accepted at cyc 3, done at cyc 10, rec_ready=1 → one record {3,10,7,0}, rec_valid pulses one cycle.
- Pipelined kernel: starts at cyc 2,4,6; dones at 9,11,13 → latencies 7,7,7; intervals 0,2,2; records in order.
- Same-cycle start+done with queue empty at cyc 5 → record {5,5,0,0}; no error flags.
- Backpressure: rec_ready=0, 10 completions with OUT_DEPTH=8 → 8 records held, drop_count=2, err_overflow=1; a start at queue-full raises err_excess.
- Orphan done at cyc 1 → err_orphan=1, rec_valid stays 0. Timestamp wrap with TS_W=4: start at 14, done at 3 → latency 5.
- finish with 3 records queued, rec_ready toggling → all 3 emitted, then drained=1; reset mid-DRAIN → IDLE, all outputs 0.

Source files
------------

// File: rtl/hs_track_pkg.sv
// Shared types and default sizes for the ap_ctrl_hs handshake tracker.
package hs_track_pkg;

  localparam int TS_W_DEF      = 32;
  localparam int OUT_DEPTH_DEF = 8;
  localparam int MAX_OUT_DEF   = 4;

  // Fields are sized for the widest timestamp; narrower trackers zero-extend.
  typedef struct packed {
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] done_ts;
    logic [TS_W_DEF-1:0] latency;
    logic [TS_W_DEF-1:0] interval;
  } rec_t;

  typedef struct packed {
    logic [TS_W_DEF-1:0] start_ts;
    logic [TS_W_DEF-1:0] interval;
  } inflight_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/hs_track_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible while not empty.
// A write into a full FIFO succeeds when a read happens in the same cycle.
module hs_track_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr, do_rd;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/ap_handshake_tracker.sv
// Tracks one kernel's ap_ctrl_hs handshake and streams one timing record per
// completed transaction (start, done, latency, start-to-start interval).
module ap_handshake_tracker
  import hs_track_pkg::*;
#(
  parameter int TS_W      = TS_W_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            finish,
  input  logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  input  logic            ap_continue,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_done_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic            err_overflow,
  output logic            err_orphan,
  output logic            err_excess,
  output logic [15:0]     drop_count,
  output logic            drained
);

  localparam int QCW = $clog2(MAX_OUT + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  state_t          state_reg;
  logic [TS_W-1:0] cyc_reg, last_start_reg;
  logic            have_start_reg;
  logic            err_overflow_reg, err_orphan_reg, err_excess_reg, drained_reg;
  logic [15:0]     drop_count_reg;

  logic            run, start_ev, done_ev, bypass, orphan, excess;
  logic [TS_W-1:0] interval, latency;
  logic            q_clear, q_push, q_pop, q_full, q_empty;
  logic [QCW-1:0]  q_count;
  inflight_t       q_wr, q_head;
  logic            o_push, o_pop, o_drop, o_full, o_empty;
  logic [OCW-1:0]  o_count;
  rec_t            rec_in, o_head;
  logic            unused_bits;

  assign run      = (state_reg == RUN);
  assign start_ev = run & ap_start & ap_ready;
  assign done_ev  = run & ap_done & ap_continue;

  // A done with nothing in flight pairs with a same-cycle start (zero latency).
  assign q_pop    = done_ev & ~q_empty;
  assign bypass   = done_ev & q_empty & start_ev;
  assign orphan   = done_ev & q_empty & ~start_ev;
  assign q_push   = start_ev & ~bypass & (~q_full | q_pop);
  assign excess   = start_ev & q_full & ~q_pop;
  assign interval = have_start_reg ? cyc_reg - last_start_reg : '0;
  assign latency  = cyc_reg - q_head.start_ts[TS_W-1:0];
  assign q_clear  = reset | (state_reg == DRAIN);
  assign q_wr     = '{start_ts: TS_W_DEF'(cyc_reg), interval: TS_W_DEF'(interval)};

  always_comb begin
    rec_in         = '0;
    rec_in.done_ts = TS_W_DEF'(cyc_reg);
    if (bypass) begin
      rec_in.start_ts = TS_W_DEF'(cyc_reg);
      rec_in.interval = TS_W_DEF'(interval);
    end else begin
      rec_in.start_ts = q_head.start_ts;
      rec_in.latency  = TS_W_DEF'(latency);
      rec_in.interval = q_head.interval;
    end
  end

  assign o_push = q_pop | bypass;
  assign o_pop  = ~o_empty & rec_ready;
  assign o_drop = o_push & o_full & ~o_pop;

  hs_track_fifo #(.WIDTH($bits(inflight_t)), .DEPTH(MAX_OUT)) u_inflight (
    .clock   (clock),
    .reset   (q_clear),
    .wr_en   (q_push),
    .wr_data (q_wr),
    .rd_en   (q_pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  hs_track_fifo #(.WIDTH($bits(rec_t)), .DEPTH(OUT_DEPTH)) u_out (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (o_push),
    .wr_data (rec_in),
    .rd_en   (rec_ready),
    .rd_data (o_head),
    .full    (o_full),
    .empty   (o_empty),
    .count   (o_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cyc_reg          <= '0;
      last_start_reg   <= '0;
      have_start_reg   <= 1'b0;
      err_overflow_reg <= 1'b0;
      err_orphan_reg   <= 1'b0;
      err_excess_reg   <= 1'b0;
      drop_count_reg   <= '0;
      drained_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (enable) state_reg <= RUN;
        RUN: begin
          cyc_reg <= cyc_reg + TS_W'(1);
          if (finish) state_reg <= DRAIN;
        end
        DRAIN: if (o_empty) begin
          state_reg   <= DONE;
          drained_reg <= 1'b1;
        end
        default: ;
      endcase
      if (start_ev) begin
        last_start_reg <= cyc_reg;
        have_start_reg <= 1'b1;
      end
      if (orphan) err_orphan_reg <= 1'b1;
      if (excess) err_excess_reg <= 1'b1;
      if (o_drop) begin
        err_overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign rec_valid    = ~o_empty;
  assign rec_start_ts = rec_valid ? o_head.start_ts[TS_W-1:0] : '0;
  assign rec_done_ts  = rec_valid ? o_head.done_ts[TS_W-1:0]  : '0;
  assign rec_latency  = rec_valid ? o_head.latency[TS_W-1:0]  : '0;
  assign rec_interval = rec_valid ? o_head.interval[TS_W-1:0] : '0;
  assign err_overflow = err_overflow_reg;
  assign err_orphan   = err_orphan_reg;
  assign err_excess   = err_excess_reg;
  assign drop_count   = drop_count_reg;
  assign drained      = drained_reg;

  // Occupancy counts and the upper field bits of narrow trackers are not needed.
  assign unused_bits = ^{q_count, o_count, q_head, o_head};

endmodule

// File: tb/tb_ap_handshake_tracker.sv
// Directed bench for ap_handshake_tracker: a 32-bit and a 4-bit tracker share
// stimulus and are compared every cycle against a queue-level reference model.
module tb_ap_handshake_tracker;

  logic clock = 1'b0;
  logic reset, enable, finish, ap_start, ap_ready, ap_done, ap_continue, rec_ready;
  logic        rec_valid, err_overflow, err_orphan, err_excess, drained;
  logic [31:0] rec_start_ts, rec_done_ts, rec_latency, rec_interval;
  logic [15:0] drop_count;
  logic        rec4_valid, err4_overflow, err4_orphan, err4_excess, drained4;
  logic [3:0]  rec4_start_ts, rec4_done_ts, rec4_latency, rec4_interval;
  logic [15:0] drop4_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;

  always #5 clock = ~clock;

  ap_handshake_tracker dut (
    .clock(clock), .reset(reset), .enable(enable), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_start_ts(rec_start_ts), .rec_done_ts(rec_done_ts),
    .rec_latency(rec_latency), .rec_interval(rec_interval),
    .err_overflow(err_overflow), .err_orphan(err_orphan), .err_excess(err_excess),
    .drop_count(drop_count), .drained(drained)
  );

  ap_handshake_tracker #(.TS_W(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rec_valid(rec4_valid), .rec_ready(rec_ready),
    .rec_start_ts(rec4_start_ts), .rec_done_ts(rec4_done_ts),
    .rec_latency(rec4_latency), .rec_interval(rec4_interval),
    .err_overflow(err4_overflow), .err_orphan(err4_orphan), .err_excess(err4_excess),
    .drop_count(drop4_count), .drained(drained4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] s, d, l, i; } mrec_t;
  mrec_t       oq[$];
  logic [31:0] qs[$];
  logic [31:0] qi[$];
  int          m_state = 0;   // 0 idle, 1 run, 2 drain, 3 done
  logic [31:0] m_cyc, m_last, m_iv;
  bit          m_have, m_ovf, m_orph, m_exc, m_ok = 0;
  int          m_drop, m_sz0;
  bit          m_opop, m_st, m_dn, m_used, m_hr;
  mrec_t       m_r, m_e;

  task automatic compare_all();
    if (oq.size() != 0) m_e = oq[0];
    else m_e = '{0, 0, 0, 0};
    check("rec_valid", rec_valid, oq.size() != 0);
    check("rec_start_ts", rec_start_ts, m_e.s);
    check("rec_done_ts", rec_done_ts, m_e.d);
    check("rec_latency", rec_latency, m_e.l);
    check("rec_interval", rec_interval, m_e.i);
    check("err_overflow", err_overflow, m_ovf);
    check("err_orphan", err_orphan, m_orph);
    check("err_excess", err_excess, m_exc);
    check("drop_count", drop_count, m_drop);
    check("drained", drained, m_state == 3);
    check("w4_rec_valid", rec4_valid, oq.size() != 0);
    check("w4_fields", {rec4_start_ts, rec4_done_ts, rec4_latency, rec4_interval},
          {m_e.s[3:0], m_e.d[3:0], m_e.l[3:0], m_e.i[3:0]});
    check("w4_flags", {err4_overflow, err4_orphan, err4_excess, drained4},
          {m_ovf, m_orph, m_exc, m_state == 3});
    check("w4_drop_count", drop4_count, m_drop);
    if (rec_valid && rec_ready)
      $display("record start=%0d done=%0d latency=%0d interval=%0d",
               rec_start_ts, rec_done_ts, rec_latency, rec_interval);
  endtask

  always @(negedge clock) begin
    if (m_ok) compare_all();
    if (reset) begin
      oq.delete(); qs.delete(); qi.delete();
      m_state = 0; m_cyc = 0; m_last = 0; m_have = 0;
      m_ovf = 0; m_orph = 0; m_exc = 0; m_drop = 0; m_ok = 1;
    end else if (m_ok) begin
      m_sz0  = oq.size();
      m_opop = (m_sz0 != 0) && rec_ready;
      m_st   = (m_state == 1) && ap_start && ap_ready;
      m_dn   = (m_state == 1) && ap_done && ap_continue;
      m_iv   = m_have ? m_cyc - m_last : 32'd0;
      m_used = 0;
      m_hr   = 0;
      if (m_opop) void'(oq.pop_front());
      if (m_dn) begin
        if (qs.size() != 0) begin
          m_r.s = qs.pop_front();
          m_r.i = qi.pop_front();
          m_r.d = m_cyc;
          m_r.l = m_cyc - m_r.s;
          m_hr  = 1;
        end else if (m_st) begin
          m_r = '{m_cyc, m_cyc, 0, m_iv};
          m_hr = 1;
          m_used = 1;
        end else m_orph = 1;
      end
      if (m_st && !m_used) begin
        if (qs.size() < 4) begin qs.push_back(m_cyc); qi.push_back(m_iv); end
        else m_exc = 1;
      end
      if (m_st) begin m_last = m_cyc; m_have = 1; end
      if (m_hr) begin
        if (oq.size() < 8) oq.push_back(m_r);
        else begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: begin m_cyc = m_cyc + 1; if (finish) m_state = 2; end
        2: begin qs.delete(); qi.delete(); if (m_sz0 == 0) m_state = 3; end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    tcyc++;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic start_run();
    enable = 1; tick(); enable = 0; tcyc = 0;
  endtask

  task automatic goto_cyc(input int t);
    while (tcyc < t) tick();
  endtask

  task automatic pulse(input bit s, input bit d);
    ap_start = s; ap_ready = s; ap_done = d; ap_continue = d;
    tick();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
  endtask

  task automatic expect_rec(input string tag, input int s, input int d, input int l, input int i);
    check({tag, "_valid"}, rec_valid, 1);
    check({tag, "_rec"}, {rec_start_ts[7:0], rec_done_ts[7:0], rec_latency[7:0], rec_interval[7:0]},
          {s[7:0], d[7:0], l[7:0], i[7:0]});
  endtask

  int pops;

  initial begin
    reset = 1; enable = 0; finish = 0; rec_ready = 1;
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    tick(); tick(); reset = 0; tick();
    check("rst_valid", rec_valid, 0);
    check("rst_fields", rec_start_ts | rec_done_ts | rec_latency | rec_interval, 0);
    check("rst_flags", {err_overflow, err_orphan, err_excess, drained}, 0);
    check("rst_drop", drop_count, 0);

    // single transaction
    start_run(); goto_cyc(3); pulse(1, 0); goto_cyc(10); pulse(0, 1);
    expect_rec("single", 3, 10, 7, 0);
    tick();
    check("single_pulse", rec_valid, 0);

    // pipelined kernel
    do_reset(); start_run();
    goto_cyc(2); pulse(1, 0); goto_cyc(4); pulse(1, 0); goto_cyc(6); pulse(1, 0);
    goto_cyc(9);  pulse(0, 1); expect_rec("pipe0", 2, 9, 7, 0);
    goto_cyc(11); pulse(0, 1); expect_rec("pipe1", 4, 11, 7, 2);
    goto_cyc(13); pulse(0, 1); expect_rec("pipe2", 6, 13, 7, 2);

    // same-cycle start and done with nothing in flight
    do_reset(); start_run(); goto_cyc(5); pulse(1, 1);
    expect_rec("bypass", 5, 5, 0, 0);
    check("bypass_flags", {err_overflow, err_orphan, err_excess}, 0);

    // backpressure, overflow and excess
    do_reset(); rec_ready = 0; start_run();
    for (int k = 0; k < 10; k++) pulse(1, 1);
    check("bp_drop", drop_count, 2);
    check("bp_ovf", err_overflow, 1);
    expect_rec("bp_head", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) pulse(1, 0);
    check("bp_no_excess", err_excess, 0);
    pulse(1, 0);
    check("bp_excess", err_excess, 1);
    pulse(1, 1);
    check("bp_drop3", drop_count, 3);
    rec_ready = 1;
    pulse(0, 1);
    check("bp_pop_push", drop_count, 3);
    pulse(0, 1); pulse(0, 1); pulse(0, 1);
    for (int k = 0; k < 12; k++) tick();
    check("bp_empty", rec_valid, 0);

    // qualifier-only activity, then an orphan done
    do_reset(); start_run();
    ap_start = 1; ap_done = 1; tick(); ap_start = 0; ap_done = 0;
    check("orph_none", err_orphan, 0);
    pulse(0, 1);
    check("orph_set", err_orphan, 1);
    check("orph_novalid", rec_valid, 0);

    // timestamp wrap on the 4-bit tracker
    do_reset(); start_run(); goto_cyc(14); pulse(1, 0); goto_cyc(19); pulse(0, 1);
    expect_rec("wrap32", 14, 19, 5, 0);
    check("wrap4", {rec4_start_ts, rec4_done_ts, rec4_latency}, {4'd14, 4'd3, 4'd5});

    // drain with toggling ready
    do_reset(); rec_ready = 0; start_run();
    pulse(1, 1); pulse(1, 1); pulse(1, 1);
    finish = 1; tick(); finish = 0;
    pulse(1, 1);
    pops = 0;
    for (int k = 0; k < 40 && !drained; k++) begin
      rec_ready = ~rec_ready;
      if (rec_valid && rec_ready) pops++;
      tick();
    end
    check("drain_pops", pops, 3);
    check("drain_done", drained, 1);

    // reset in the middle of a drain
    do_reset(); rec_ready = 0; start_run();
    pulse(1, 1); pulse(1, 1);
    finish = 1; tick(); finish = 0; tick(); tick();
    check("mid_drain_drained", drained, 0);
    check("mid_drain_valid", rec_valid, 1);
    reset = 1; tick(); reset = 0;
    check("mid_rst_valid", rec_valid, 0);
    check("mid_rst_fields", rec_start_ts | rec_done_ts | rec_latency | rec_interval, 0);
    check("mid_rst_flags", {err_overflow, err_orphan, err_excess, drained}, 0);
    pulse(1, 1);
    check("idle_ignored", rec_valid, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
